// File: rtl/shift_reg_piso_tx_pkg.sv
// Shared types and sizing helpers for the PISO serializer and its bit counter.
package shift_reg_piso_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter width for a WIDTH-bit frame; never less than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// WIDTH-modulo bit counter with enable and synchronous active-low clear.
// One-cycle update; tc flags the final bit position (WIDTH-1).
module piso_bit_cnt
    import shift_reg_piso_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: first bit one cycle after load, advances on shift_en.
// load_ready is high in IDLE or on the final-bit advance, allowing gapless back-to-back frames.
module shift_reg_piso_tx
    import shift_reg_piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int CW = cnt_w(WIDTH);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             cnt_tc;
    logic             in_shift;
    logic             load;
    logic             advance;
    logic             head_bit;

    assign in_shift   = (state == SHIFT);
    assign advance    = in_shift & shift_en;
    assign sout_last  = in_shift & cnt_tc;
    assign load_ready = reset_n & (~in_shift | (sout_last & shift_en));
    assign load       = load_valid & load_ready;

    assign head_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign sout       = in_shift & head_bit;
    assign sout_valid = in_shift;

    // A load restarts the count even when it coincides with the wrap edge.
    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .clr_n (reset_n & ~load),
        .en    (advance),
        .cnt   (bit_cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            shreg <= '0;
        end else if (load) begin
            state <= SHIFT;
            shreg <= d;
        end else if (advance) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            if (cnt_tc) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed, table-driven bench for shift_reg_piso_tx (WIDTH=4, both bit orders).
module tb_shift_reg_piso_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid;
    logic       shift_en;
    logic [3:0] d;

    logic load_ready, sout, sout_valid, sout_last;
    logic lsb_ready, lsb_sout, lsb_valid, lsb_last;

    always #5 clk = ~clk;

    shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (lsb_ready),
        .shift_en   (shift_en),
        .sout       (lsb_sout),
        .sout_valid (lsb_valid),
        .sout_last  (lsb_last)
    );

    // Each row: inputs held for one cycle, and the outputs expected during that
    // cycle (before the edge that consumes the inputs).
    typedef struct {
        logic       rst_n;
        logic       lv;
        logic [3:0] d;
        logic       se;
        logic       chk;
        logic       sout;
        logic       vld;
        logic       last;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic rst_n, input logic lv, input logic [3:0] dv,
                                input logic se, input logic chk, input logic so,
                                input logic vld, input logic last, input logic rdy);
        vec_t v;
        v.rst_n = rst_n; v.lv = lv; v.d = dv; v.se = se; v.chk = chk;
        v.sout = so; v.vld = vld; v.last = last; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic lv, input logic [3:0] dv, input logic se);
        @(negedge clk);
        reset_n    = rst_n;
        load_valid = lv;
        d          = dv;
        shift_en   = se;
        #1;
    endtask

    initial begin
        logic [3:0] lsb_exp;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        d          = 4'b0000;

        //                rst lv  d        se chk so vld lst rdy
        // Reset, then 1011 with shift_en constant
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1011, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 0, 0, 0, 1));
        // 1100 with shift_en stalls: second bit held three cycles
        vecs.push_back(mk(1, 1, 4'b1100, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 1));
        // Back-to-back 1010 then 0101, load_valid held
        vecs.push_back(mk(1, 1, 4'b1010, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4'b0101, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b0101, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b0101, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b0101, 1, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 1));
        // 1011 captured, d toggling with load_valid high mid-frame
        vecs.push_back(mk(1, 1, 4'b1011, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4'b0000, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1111, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1111, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 1));
        // 1111 abandoned by reset on the second bit
        vecs.push_back(mk(1, 1, 4'b1111, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].lv, vecs[i].d, vecs[i].se);
            if (vecs[i].chk) begin
                check($sformatf("v%0d sout", i),       sout,       vecs[i].sout);
                check($sformatf("v%0d sout_valid", i), sout_valid, vecs[i].vld);
                check($sformatf("v%0d sout_last", i),  sout_last,  vecs[i].last);
                check($sformatf("v%0d load_ready", i), load_ready, vecs[i].rdy);
            end else begin
                check($sformatf("v%0d load_ready_in_reset", i), load_ready, 1'b0);
            end
        end

        // LSB-first instance: 1011 must come out as 1,1,0,1
        lsb_exp = 4'b1011;
        drive(1, 1, 4'b1011, 1);
        check("lsb load_ready idle", lsb_ready, 1'b1);
        check("lsb sout_valid idle", lsb_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 4'b0000, 1);
            check($sformatf("lsb bit%0d sout", k),  lsb_sout,  lsb_exp[k]);
            check($sformatf("lsb bit%0d valid", k), lsb_valid, 1'b1);
            check($sformatf("lsb bit%0d last", k),  lsb_last,  (k == 3) ? 1'b1 : 1'b0);
        end
        drive(1, 0, 4'b0000, 1);
        check("lsb sout_valid after frame", lsb_valid, 1'b0);
        check("lsb sout after frame",       lsb_sout,  1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
